// File: rtl/linear_network_pkg.sv
// linear_network_pkg: request record, dummy-data constant and pointer-width helper shared by the linear multicast network blocks.
package linear_network_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_NODE = 4;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_NODE-1:0]   mask;
  } mcast_req_t;
  localparam logic [DATA_WIDTH-1:0] DUMMY_DATA = '0;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/linear_network_req_fifo.sv
// linear_network_req_fifo: request FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module linear_network_req_fifo
  import linear_network_pkg::*;
#(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [ptr_w(DEPTH):0]  o_count
);
  localparam int AW = ptr_w(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;
  assign o_empty = r_wr == r_rd;
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count = r_wr - r_rd;
  assign o_rdata = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk)
    if (i_push && !o_full) r_mem[r_wr[AW-1:0]] <= i_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push && !o_full) r_wr <= r_wr + 1'b1;
      if (i_pop && !o_empty) r_rd <= r_rd + 1'b1;
    end
endmodule

// File: rtl/linear_network_multicast_injector.sv
// linear_network_multicast_injector: queues {data, mask} requests and issues one registered request per cycle into the network.
// Optional zero-mask drop counter port o_drop_cnt under LINEAR_NETWORK_MULTICAST_INJECTOR_DROP_CNT_EN.
module linear_network_multicast_injector
  import linear_network_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  input  logic [DATA_WIDTH-1:0]         i_data_bus,
  input  logic [NUM_NODE-1:0]           i_dest_mask,
  output logic                          o_ready,
  input  logic                          i_drain_en,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_data_bus,
  output logic [NUM_NODE-1:0]           o_cmd,
  output logic                          o_en,
`ifdef LINEAR_NETWORK_MULTICAST_INJECTOR_DROP_CNT_EN
  output logic [15:0]                   o_drop_cnt,
`endif
  output logic [ptr_w(FIFO_DEPTH):0]    o_count
);
  logic [DATA_WIDTH+NUM_NODE-1:0] w_head;
  logic w_full, w_empty, w_accept, w_push, w_pop;
  logic r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [NUM_NODE-1:0] r_cmd;
  assign o_ready  = !w_full;
  assign w_accept = i_valid && o_ready;
  assign w_push   = w_accept && |i_dest_mask;
  assign w_pop    = i_drain_en && !w_empty;
  linear_network_req_fifo #(.W(DATA_WIDTH + NUM_NODE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({i_data_bus, i_dest_mask}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_count)
  );
  // Idle cycles drive the network's all-zero dummy word rather than stale data.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cmd   <= '0;
    end else begin
      r_valid <= w_pop;
      r_data  <= w_pop ? w_head[DATA_WIDTH+NUM_NODE-1:NUM_NODE] : DATA_WIDTH'(DUMMY_DATA);
      r_cmd   <= w_pop ? w_head[NUM_NODE-1:0] : '0;
    end
  assign o_valid    = r_valid;
  assign o_en       = r_valid;
  assign o_data_bus = r_data;
  assign o_cmd      = r_cmd;
`ifdef LINEAR_NETWORK_MULTICAST_INJECTOR_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_drop_cnt <= '0;
    else if (w_accept && !(|i_dest_mask) && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  assign o_drop_cnt = r_drop_cnt;
`endif
endmodule

// File: tb/tb_linear_network_multicast_injector.sv
// tb_linear_network_multicast_injector: directed vector table plus back-pressure, wrap-around and reset sequences.
module tb_linear_network_multicast_injector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic [31:0] i_data_bus = '0;
  logic [3:0] i_dest_mask = '0;
  logic i_drain_en = 1'b0;
  logic o_ready, o_valid, o_en;
  logic [31:0] o_data_bus;
  logic [3:0] o_cmd;
  logic [2:0] o_count;
`ifdef LINEAR_NETWORK_MULTICAST_INJECTOR_DROP_CNT_EN
  logic [15:0] o_drop_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  linear_network_multicast_injector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_dest_mask(i_dest_mask),
    .o_ready    (o_ready),
    .i_drain_en (i_drain_en),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .o_cmd      (o_cmd),
    .o_en       (o_en),
`ifdef LINEAR_NETWORK_MULTICAST_INJECTOR_DROP_CNT_EN
    .o_drop_cnt (o_drop_cnt),
`endif
    .o_count    (o_count)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [3:0]  m;
    logic        dr;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ec;
    logic [2:0]  en;
    logic        er;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] m, input logic dr);
    i_valid = v;
    i_data_bus = d;
    i_dest_mask = m;
    i_drain_en = dr;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [31:0] d, input logic [3:0] c);
    chk({nm, "_valid"}, {31'b0, o_valid}, {31'b0, v});
    chk({nm, "_en"}, {31'b0, o_en}, {31'b0, v});
    chk({nm, "_data"}, o_data_bus, d);
    chk({nm, "_cmd"}, {28'b0, o_cmd}, {28'b0, c});
  endtask

  function automatic logic [31:0] wd(input int j);
    return 32'h100 + j;
  endfunction

  function automatic logic [3:0] wm(input int j);
    logic [3:0] one;
    one = 4'b0001;
    return one << (j % 4);
  endfunction

  initial begin
    // row: inputs during the cycle, outputs expected in that cycle before its closing edge
    tbl.push_back('{1'b0, 32'h0,         4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 3'd0, 1'b1});
    tbl.push_back('{1'b1, 32'hA5A5_0001, 4'b0100, 1'b1, 1'b0, 32'h0,         4'b0000, 3'd0, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 3'd1, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         4'b0000, 1'b1, 1'b1, 32'hA5A5_0001, 4'b0100, 3'd0, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 3'd0, 1'b1});
    tbl.push_back('{1'b1, 32'hB000_0001, 4'b1111, 1'b1, 1'b0, 32'h0,         4'b0000, 3'd0, 1'b1});
    tbl.push_back('{1'b1, 32'hB000_0002, 4'b0011, 1'b1, 1'b0, 32'h0,         4'b0000, 3'd1, 1'b1});
    tbl.push_back('{1'b1, 32'hB000_0003, 4'b1000, 1'b1, 1'b1, 32'hB000_0001, 4'b1111, 3'd1, 1'b1});
    tbl.push_back('{1'b1, 32'hB000_0004, 4'b0101, 1'b1, 1'b1, 32'hB000_0002, 4'b0011, 3'd1, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         4'b0000, 1'b1, 1'b1, 32'hB000_0003, 4'b1000, 3'd1, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         4'b0000, 1'b1, 1'b1, 32'hB000_0004, 4'b0101, 3'd0, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 3'd0, 1'b1});
    tbl.push_back('{1'b1, 32'hC000_0010, 4'b0001, 1'b1, 1'b0, 32'h0,         4'b0000, 3'd0, 1'b1});
    tbl.push_back('{1'b1, 32'hC000_0011, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 3'd1, 1'b1});
    tbl.push_back('{1'b1, 32'hC000_0012, 4'b0010, 1'b1, 1'b1, 32'hC000_0010, 4'b0001, 3'd0, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 3'd1, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         4'b0000, 1'b1, 1'b1, 32'hC000_0012, 4'b0010, 3'd0, 1'b1});
    tbl.push_back('{1'b0, 32'h0,         4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 3'd0, 1'b1});

    #2;
    chk("reset_valid", {31'b0, o_valid}, 32'd0);
    chk("reset_count", {29'b0, o_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].m, tbl[i].dr);
      chk_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec);
      chk($sformatf("row%0d_count", i), {29'b0, o_count}, {29'b0, tbl[i].en});
      chk($sformatf("row%0d_ready", i), {31'b0, o_ready}, {31'b0, tbl[i].er});
      tick();
    end
`ifdef LINEAR_NETWORK_MULTICAST_INJECTOR_DROP_CNT_EN
    chk("drop_cnt", {16'b0, o_drop_cnt}, 32'd1);
`endif

    // back-pressure: fifth push refused while drain is held off
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h20 + i, wm(i), 1'b0);
      chk($sformatf("full_ready%0d", i), {31'b0, o_ready}, {31'b0, i < 4});
      tick();
    end
    drive(1'b0, 32'h0, 4'b0000, 1'b0);
    chk("full_count", {29'b0, o_count}, 32'd4);
    chk_out("full_hold", 1'b0, 32'h0, 4'b0000);
    i_drain_en = 1'b1;
    chk("full_no_passthru", {31'b0, o_ready}, 32'd0);
    tick();
    chk("full_ready_rise", {31'b0, o_ready}, 32'd1);
    chk("full_count3", {29'b0, o_count}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("full_pulse%0d", i), 1'b1, 32'h20 + i, wm(i));
      tick();
    end
    chk_out("full_done", 1'b0, 32'h0, 4'b0000);
    chk("full_empty", {29'b0, o_count}, 32'd0);

    // wrap-around: steady push+pop at occupancy 2
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, wd(j), wm(j), 1'b0);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, wd(k + 2), wm(k + 2), 1'b1);
      chk($sformatf("wrap_count%0d", k), {29'b0, o_count}, 32'd2);
      if (k == 0) chk_out("wrap_idle", 1'b0, 32'h0, 4'b0000);
      else chk_out($sformatf("wrap%0d", k), 1'b1, wd(k - 1), wm(k - 1));
      tick();
    end
    drive(1'b0, 32'h0, 4'b0000, 1'b1);
    for (int k = 9; k < 12; k++) begin
      chk_out($sformatf("wrap_tail%0d", k), 1'b1, wd(k), wm(k));
      tick();
    end
    chk_out("wrap_end", 1'b0, 32'h0, 4'b0000);
    chk("wrap_empty", {29'b0, o_count}, 32'd0);

    // reset mid-burst with a pulse in flight
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 32'h300 + j, 4'b1001, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 4'b0000, 1'b1);
    tick();
    chk_out("rst_pre", 1'b1, 32'h300, 4'b1001);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst_async", 1'b0, 32'h0, 4'b0000);
    chk("rst_count", {29'b0, o_count}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef LINEAR_NETWORK_MULTICAST_INJECTOR_DROP_CNT_EN
    chk("rst_drop_cnt", {16'b0, o_drop_cnt}, 32'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_quiet%0d", k), {31'b0, o_valid}, 32'd0);
      chk($sformatf("rst_cnt%0d", k), {29'b0, o_count}, 32'd0);
      tick();
    end
    drive(1'b1, 32'h400, 4'b0110, 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'b0000, 1'b1);
    chk_out("rst_new_wait", 1'b0, 32'h0, 4'b0000);
    tick();
    chk_out("rst_new", 1'b1, 32'h400, 4'b0110);
    tick();
    chk_out("rst_new_end", 1'b0, 32'h0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
